nf10_axis_capture: RTL and testbench

NF10_AXIS_CAPTURE -- requirements
Module: nf10_axis_capture

---
 rtl/nf10_axis_capture_pkg.sv | 17 +
 rtl/nf10_capture_fifo.sv | 58 +++++
 rtl/nf10_axis_capture.sv | 150 +++++++++++++++
 tb/tb_nf10_axis_capture.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_capture_pkg.sv
// Shared types and helpers for nf10_axis_capture: input FSM states, timestamp width, pointer sizing.
package nf10_axis_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } cap_state_e;

  localparam int TS_WIDTH = 32;

  // Index bits plus one wrap bit, so equal indices can be told apart as full or empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/nf10_capture_fifo.sv
// Synchronous show-ahead FIFO: head entry is on rd_data combinationally, a write shows on the next cycle.
// Writes while full and reads while empty are ignored; level counts stored entries.
module nf10_capture_fifo
  import nf10_axis_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [ptr_width(DEPTH)-1:0] level
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + (do_wr ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (do_rd ? PTR_W'(1) : PTR_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/nf10_axis_capture.sv
// AXI-Stream beat capture into a show-ahead buffer; NF10_AXIS_CAPTURE_TIMESTAMP_EN adds a per-beat cycle stamp.
// Beats are stored on the accepting edge and readable the next cycle; when full, drops (C_STALL_MODE=0) or deasserts tready (1).
module nf10_axis_capture
  import nf10_axis_capture_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH              = 64,
  parameter int C_STALL_MODE         = 0
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    rd_data,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  rd_strb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   rd_user,
  output logic                              rd_last,
  output logic [TS_WIDTH-1:0]               rd_timestamp,
  output logic [7:0]                        counter,
  output logic                              activity_rec,
  output logic                              overflow,
  output logic [ptr_width(C_DEPTH)-1:0]     level
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
`ifdef NF10_AXIS_CAPTURE_TIMESTAMP_EN
  localparam int ENT_W = TS_WIDTH + 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_DATA_WIDTH;
`else
  localparam int ENT_W = 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_DATA_WIDTH;
`endif

  if ((C_S_AXIS_DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("nf10_axis_capture: C_S_AXIS_DATA_WIDTH must be a multiple of 8");
  end
  if ((C_DEPTH < 4) || ((C_DEPTH & (C_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("nf10_axis_capture: C_DEPTH must be a power of 2 and at least 4");
  end
  if ((C_STALL_MODE != 0) && (C_STALL_MODE != 1)) begin : g_bad_stall_mode
    $error("nf10_axis_capture: C_STALL_MODE must be 0 or 1");
  end

  cap_state_e       state_q, state_d;
  logic [7:0]       counter_q, counter_d;
  logic             overflow_q, overflow_d;
  logic             activity_q, activity_d;
  logic             beat_acc, beat_drop, fifo_wr, pkt_done;
  logic             fifo_full, fifo_empty;
  logic [ENT_W-1:0] wr_entry, rd_entry;

  // Drop mode never stalls: a full buffer is handled by discarding, not by backpressure.
  assign s_axis_tready = !reset && ((C_STALL_MODE != 0) ? !fifo_full : 1'b1);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    fifo_wr   = 1'b0;
    beat_drop = 1'b0;
    pkt_done  = 1'b0;
    if (beat_acc) begin
      case (state_q)
        ST_DROP: begin
          beat_drop = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: begin
          // Full is judged on registered pointers, so a same-cycle pop cannot rescue this beat.
          if (fifo_full) begin
            beat_drop = 1'b1;
            state_d   = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            fifo_wr  = 1'b1;
            pkt_done = s_axis_tlast;
            state_d  = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
          end
        end
      endcase
    end
  end

  always_comb begin
    counter_d  = counter_q + (pkt_done ? 8'd1 : 8'd0);
    overflow_d = overflow_q | beat_drop;
    activity_d = beat_acc;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      counter_q  <= 8'd0;
      overflow_q <= 1'b0;
      activity_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      overflow_q <= overflow_d;
      activity_q <= activity_d;
    end
  end

`ifdef NF10_AXIS_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_entry = {ts_q, s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign {rd_timestamp, rd_last, rd_user, rd_strb, rd_data} = rd_entry;
`else
  assign wr_entry     = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
  assign {rd_last, rd_user, rd_strb, rd_data} = rd_entry;
  assign rd_timestamp = '0;
`endif

  nf10_capture_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (C_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd_valid     = !fifo_empty;
  assign counter      = counter_q;
  assign overflow     = overflow_q;
  assign activity_rec = activity_q;

endmodule

// File: tb/tb_nf10_axis_capture.sv
// Bench for nf10_axis_capture: drop-mode and stall-mode instances (depth 4) checked against a queue-based model.
module tb_nf10_axis_capture;

  localparam int DW    = 64;
  localparam int UW    = 16;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  typedef struct packed {
    logic [31:0]   ts;
    logic          last;
    logic [UW-1:0] user;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } ent_t;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic          rst_i    [2];
  logic [DW-1:0] tdata_i  [2];
  logic [SW-1:0] tstrb_i  [2];
  logic [UW-1:0] tuser_i  [2];
  logic          tvalid_i [2];
  logic          tlast_i  [2];
  logic          rd_en_i  [2];
  logic          tready_o [2];
  logic          rd_valid_o [2];
  logic [DW-1:0] rd_data_o  [2];
  logic [SW-1:0] rd_strb_o  [2];
  logic [UW-1:0] rd_user_o  [2];
  logic          rd_last_o  [2];
  logic [31:0]   rd_ts_o    [2];
  logic [7:0]    counter_o  [2];
  logic          act_o      [2];
  logic          ovf_o      [2];
  logic [LW-1:0] level_o    [2];

  // Instance 0 drops when full, instance 1 backpressures.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    nf10_axis_capture #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .C_DEPTH              (DEPTH),
      .C_STALL_MODE         (g)
    ) u_dut (
      .aclk          (aclk),
      .reset         (rst_i[g]),
      .s_axis_tdata  (tdata_i[g]),
      .s_axis_tstrb  (tstrb_i[g]),
      .s_axis_tuser  (tuser_i[g]),
      .s_axis_tvalid (tvalid_i[g]),
      .s_axis_tready (tready_o[g]),
      .s_axis_tlast  (tlast_i[g]),
      .rd_en         (rd_en_i[g]),
      .rd_valid      (rd_valid_o[g]),
      .rd_data       (rd_data_o[g]),
      .rd_strb       (rd_strb_o[g]),
      .rd_user       (rd_user_o[g]),
      .rd_last       (rd_last_o[g]),
      .rd_timestamp  (rd_ts_o[g]),
      .counter       (counter_o[g]),
      .activity_rec  (act_o[g]),
      .overflow      (ovf_o[g]),
      .level         (level_o[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int cur   = 0;
  int obs_pulses = 0;

  // Reference model: stored beats as a queue plus packet-level flags.
  ent_t        mq[$];
  logic        m_drop;
  logic        m_ovf;
  logic        m_act;
  int          m_cnt;
  logic [31:0] m_ts;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check settled outputs, advance model, cross the rising edge.
  task automatic step(input logic v, input logic l, input logic re, input logic rst, output logic acc);
    ent_t e;
    logic rdy;
    logic full;
    e.data = {$urandom, $urandom};
    e.strb = SW'($urandom);
    e.user = UW'($urandom);
    e.last = l;
`ifdef NF10_AXIS_CAPTURE_TIMESTAMP_EN
    e.ts = m_ts;
`else
    e.ts = 32'd0;
`endif
    rst_i[cur]    = rst;
    tvalid_i[cur] = v;
    tlast_i[cur]  = l;
    rd_en_i[cur]  = re;
    tdata_i[cur]  = e.data;
    tstrb_i[cur]  = e.strb;
    tuser_i[cur]  = e.user;
    #1;
    full = (mq.size() >= DEPTH);
    rdy  = !rst && ((cur == 1) ? !full : 1'b1);
    acc  = v && rdy;
    chk_eq("tready", 64'(tready_o[cur]), 64'(rdy));
    if (!rst) begin
      chk_eq("rd_valid", 64'(rd_valid_o[cur]), 64'(mq.size() != 0));
      chk_eq("level", 64'(level_o[cur]), 64'(mq.size()));
      chk_eq("counter", 64'(counter_o[cur]), 64'(m_cnt));
      chk_eq("overflow", 64'(ovf_o[cur]), 64'(m_ovf));
      chk_eq("activity", 64'(act_o[cur]), 64'(m_act));
      if (act_o[cur]) obs_pulses++;
      if (mq.size() != 0) begin
        chk_eq("rd_data", rd_data_o[cur], mq[0].data);
        chk_eq("rd_strb", 64'(rd_strb_o[cur]), 64'(mq[0].strb));
        chk_eq("rd_user", 64'(rd_user_o[cur]), 64'(mq[0].user));
        chk_eq("rd_last", 64'(rd_last_o[cur]), 64'(mq[0].last));
        chk_eq("rd_ts", 64'(rd_ts_o[cur]), 64'(mq[0].ts));
      end
    end
    if (rst) begin
      mq.delete();
      m_drop = 1'b0; m_ovf = 1'b0; m_act = 1'b0; m_cnt = 0; m_ts = 32'd0;
    end else begin
      if (re && mq.size() != 0) void'(mq.pop_front());
      if (acc) begin
        if (m_drop) begin
          if (l) m_drop = 1'b0;
        end else if (full) begin
          m_ovf  = 1'b1;
          m_drop = !l;
        end else begin
          mq.push_back(e);
          if (l) m_cnt = (m_cnt + 1) % 256;
        end
      end
      m_act = acc;
      m_ts  = m_ts + 32'd1;
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic do_reset(input int d);
    logic acc;
    cur = d;
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 1'b0, 1'b1, acc);
    rst_i[cur] = 1'b0;
    #1;
    chk_eq("rst_level", 64'(level_o[cur]), 64'd0);
    chk_eq("rst_rd_valid", 64'(rd_valid_o[cur]), 64'd0);
    chk_eq("rst_counter", 64'(counter_o[cur]), 64'd0);
    chk_eq("rst_overflow", 64'(ovf_o[cur]), 64'd0);
    chk_eq("rst_activity", 64'(act_o[cur]), 64'd0);
    chk_eq("rst_tready_up", 64'(tready_o[cur]), 64'd1);
    obs_pulses = 0;
  endtask

  // Sends n beats (tlast on the final one); rd_en is held high once pop_from beats have been accepted.
  task automatic send_pkt(input int n, input int pop_from, input logic gaps);
    int   sent;
    int   guard;
    logic v;
    logic acc;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 20 * n + 20) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      step(v, (sent == n - 1), (sent >= pop_from), 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    if (sent < n) chk_eq("send_timeout", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int   guard;
    logic acc;
    guard = 0;
    while (mq.size() != 0 && guard < 20) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, acc);
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, acc);
    if (mq.size() != 0) chk_eq("drain_timeout", 64'(mq.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] prev_ts;
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; tvalid_i[d] = 1'b0; tlast_i[d] = 1'b0; rd_en_i[d] = 1'b0;
      tdata_i[d] = '0; tstrb_i[d] = '0; tuser_i[d] = '0;
    end

    // Three 4-beat packets read continuously.
    do_reset(0);
    for (int p = 0; p < 3; p++) send_pkt(4, 0, 1'b0);
    drain();
    chk_eq("pkts3_counter", 64'(counter_o[0]), 64'd3);
    chk_eq("pkts3_overflow", 64'(ovf_o[0]), 64'd0);
    chk_eq("pkts3_pulses", 64'(obs_pulses), 64'd12);

    // Drop mode: 6-beat packet into a depth-4 buffer with no reads.
    do_reset(0);
    send_pkt(6, 100, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk_eq("drop_level", 64'(level_o[0]), 64'd4);
    chk_eq("drop_overflow", 64'(ovf_o[0]), 64'd1);
    chk_eq("drop_counter", 64'(counter_o[0]), 64'd0);
    chk_eq("drop_pulses", 64'(obs_pulses), 64'd6);
    drain();
    send_pkt(2, 0, 1'b1);
    drain();
    chk_eq("drop_then_idle_counter", 64'(counter_o[0]), 64'd1);
    chk_eq("drop_overflow_sticky", 64'(ovf_o[0]), 64'd1);

    // Stall mode: fills after 4 beats, then reads let the packet finish.
    do_reset(1);
    for (int b = 0; b < 4; b++) step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    chk_eq("stall_tready_low", 64'(tready_o[1]), 64'd0);
    chk_eq("stall_level", 64'(level_o[1]), 64'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    send_pkt(2, 0, 1'b0);
    drain();
    chk_eq("stall_counter", 64'(counter_o[1]), 64'd1);
    chk_eq("stall_overflow", 64'(ovf_o[1]), 64'd0);

    // Counter wrap over 257 single-beat packets.
    do_reset(0);
    for (int p = 0; p < 257; p++) send_pkt(1, 0, 1'b0);
    drain();
    chk_eq("wrap_counter", 64'(counter_o[0]), 64'd1);

    // Reset on beat 2 of a 5-beat packet.
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 1'b1, acc);
    chk_eq("midrst_level", 64'(level_o[0]), 64'd0);
    chk_eq("midrst_rd_valid", 64'(rd_valid_o[0]), 64'd0);
    chk_eq("midrst_counter", 64'(counter_o[0]), 64'd0);
    send_pkt(5, 0, 1'b0);
    drain();
    chk_eq("midrst_next_counter", 64'(counter_o[0]), 64'd1);

    // Simultaneous push and pop holding level at 2.
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 1'b0, 1'b0, acc);
    prev_ts = 32'd0;
    for (int i = 0; i < 10; i++) begin
      chk_eq("pushpop_level", 64'(level_o[0]), 64'd2);
`ifdef NF10_AXIS_CAPTURE_TIMESTAMP_EN
      if (i > 0) chk_eq("pushpop_ts_incr", 64'(rd_ts_o[0] > prev_ts), 64'd1);
      prev_ts = rd_ts_o[0];
`endif
      step(1'b1, (i == 9), 1'b1, 1'b0, acc);
    end
    chk_eq("pushpop_level_end", 64'(level_o[0]), 64'd2);
    drain();

    // Random traffic on both instances, every cycle checked against the model.
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      for (int i = 0; i < 400; i++) begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), 1'b0, acc);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
